clk_tick_rx: RTL and testbench
==============================

Name: clk_tick_rx

Overview:
- Receiving end of the divided slow-clock link.
- Takes a slow clock produced by a divider, such as the 500 Hz processor step clock, and brings it into the fast clk_in domain. It emits single-cycle enable ticks on its edges, so downstream logic runs on one clock with clock enables instead of a derived clock.
- Also measures the slow clock's period and flags it lost when edges stop arriving.

Parameters:
- SYNC_STAGES, 2: synchronizer flop count on slow_clk; legal range 2..4.
- CNT_W, 18: width of the period counter and the period output.
- TIMEOUT, 250000: clk_in cycles without a rising edge before the slow clock is declared lost. Must satisfy 2 <= TIMEOUT <= 2^CNT_W - 1.

Ports:
- clk_in  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- slow_clk  input  1  divided clock; asynchronous to clk_in.
- enable  input  1  1 = detect/measure; 0 = hold in IDLE.
- tick_rise  output  1  one-cycle pulse per detected slow_clk rising edge.
- tick_fall  output  1  one-cycle pulse per detected slow_clk falling edge.
- period  output  CNT_W  clk_in cycles between the last two rising edges.
- period_valid  output  1  period holds a measurement from two consecutive edges.
- lost  output  1  slow clock timed out; no rising edge for TIMEOUT cycles.

Behaviour:
- Reset (reset=0, asynchronous): clears the synchronizer, the previous-level register, the counter and all outputs (tick_rise, tick_fall, period, period_valid, lost all 0). State goes to IDLE.
- Synchronizer: runs every cycle regardless of enable or state. sync_out is the last stage.
- Previous-level register: prev <= sync_out every cycle.
- Edge detection:
  - rise = sync_out & ~prev; fall = ~sync_out & prev.
  - tick_rise and tick_fall are registered copies of rise and fall, gated by state != IDLE.
  - Latency: tick_rise is high in the cycle after SYNC_STAGES+1 clk_in edges following the first edge that samples slow_clk=1. Default is 3 cycles.
  - Never two consecutive tick cycles for one slow_clk level change.
- Counter cnt (CNT_W bits):
  - Cleared to 0 on every rise while not IDLE.
  - Otherwise increments by 1 per cycle, saturating at TIMEOUT-1.
- State machine:
  - IDLE: enable=1 -> ACQUIRE with cnt=0. Outputs held at their reset values.
  - ACQUIRE (first rise) -> LOCKED; period and period_valid unchanged (0).
  - LOCKED (rise): period <= cnt+1, period_valid <= 1.
  - ACQUIRE or LOCKED, no rise and cnt == TIMEOUT-1 -> LOST; lost <= 1, period_valid <= 0, period retained.
  - LOST (rise) -> LOCKED; lost <= 0, period not updated. period_valid returns on the next rise.
  - Any state, enable=0 -> IDLE next cycle; lost, period_valid and period cleared.
- Simultaneous rise and timeout in the same cycle: the rise wins; no LOST entry.
- Re-enable while slow_clk is steady: no spurious tick, because prev has kept tracking sync_out.
- Example: rises N cycles apart give period = N (e.g. 200000 for 500 Hz from 100 MHz).
- Reset asserted mid-period: immediate clear. The first rise after release only re-acquires; it does not produce a measurement.

Optional Feature:
- Macro: CLK_TICK_GLITCH_FILTER_EN.
- Defined:
  - sync_out must hold a new level for 3 consecutive cycles before the filtered level changes.
  - Edge detection operates on the filtered level, which adds 2 cycles of latency (default tick_rise at 5 cycles).
  - Pulses of 1-2 cycles on slow_clk produce no tick.
- Undefined: no filter; latency as specified above; single-cycle pulses wider than one clk_in period produce ticks.

Test Plan:
1. Reset: hold reset=0 with slow_clk toggling -> all outputs 0. Release with enable=0 -> no ticks.
2. TIMEOUT=64, CNT_W=8, enable=1, slow_clk period 20 cycles:
   - first tick_rise 3 cycles after the first rise;
   - tick_fall 10 cycles after each tick_rise;
   - period_valid=1 and period=20 after the second rise.
3. Stop slow_clk after lock -> lost=1 and period_valid=0 exactly 64 cycles after the last counter clear, period still 20. Restart -> lost=0 at the first tick_rise; period_valid=1 with period=20 at the next.
4. Rise synchronized in the same cycle cnt reaches 63 -> lost stays 0, period=64.
5. Drop enable while slow_clk=1, raise it 10 cycles later with slow_clk still 1 -> no tick_rise; outputs cleared during IDLE.
6. With CLK_TICK_GLITCH_FILTER_EN:
   - 2-cycle slow_clk pulse -> no tick;
   - clean rise -> tick_rise at 5 cycles.

Source files
------------

// File: rtl/clk_tick_rx.sv
`default_nettype none
// ============================================================================
// Module   : clk_tick_rx
// Brief    : Brings a divided slow clock into the clk_in domain as one-cycle
//            rise/fall enable ticks, measures its period in clk_in cycles and
//            flags it lost when rising edges stop arriving.
//            Optional macro CLK_TICK_GLITCH_FILTER_EN adds a 3-sample level
//            filter ahead of edge detection.
// Revision : 1.0 - initial release
// ============================================================================
module clk_tick_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 18,
   parameter int TIMEOUT     = 250000
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             slow_clk,
   input  logic             enable,
   output logic             tick_rise,
   output logic             tick_fall,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             lost
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2,
      LOST    = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   sync_out;
   logic                   level;
   logic                   prev;
   logic                   rise;
   logic                   fall;

   state_t                 state;
   state_t                 state_nxt;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       cnt_nxt;
   logic [CNT_W-1:0]       period_nxt;
   logic                   valid_nxt;
   logic                   lost_nxt;
   logic                   tick_rise_nxt;
   logic                   tick_fall_nxt;

   // Metastability synchronizer for the asynchronous slow clock; always running
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], slow_clk};
      end
   end

   assign sync_out = sync[SYNC_STAGES-1];

`ifdef CLK_TICK_GLITCH_FILTER_EN
   logic hist;
   logic filt;

   // Filtered level follows sync_out only once three consecutive samples
   // agree: the stage ahead of sync_out, sync_out itself and its delayed copy.
   // Using the earlier stage keeps the added latency to two cycles.
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         hist <= 1'b0;
         filt <= 1'b0;
      end else begin
         hist <= sync_out;
         if ((sync[SYNC_STAGES-2] == sync_out) && (hist == sync_out)) begin
            filt <= sync_out;
         end
      end
   end

   assign level = filt;
`else
   assign level = sync_out;
`endif

   // Previous level tracks continuously so re-enabling never sees a stale edge
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         prev <= 1'b0;
      end else begin
         prev <= level;
      end
   end

   assign rise = level & ~prev;
   assign fall = ~level & prev;

   // Next-state, counter and measurement logic; a rise always beats a timeout
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      period_nxt    = period;
      valid_nxt     = period_valid;
      lost_nxt      = lost;
      tick_rise_nxt = rise & (state != IDLE);
      tick_fall_nxt = fall & (state != IDLE);

      if (!enable) begin
         state_nxt  = IDLE;
         cnt_nxt    = '0;
         period_nxt = '0;
         valid_nxt  = 1'b0;
         lost_nxt   = 1'b0;
      end else if (state == IDLE) begin
         state_nxt = ACQUIRE;
         cnt_nxt   = '0;
      end else if (rise) begin
         cnt_nxt = '0;
         case (state)
            ACQUIRE: state_nxt = LOCKED;
            LOCKED: begin
               period_nxt = cnt + CNT_ONE;
               valid_nxt  = 1'b1;
            end
            LOST: begin
               state_nxt = LOCKED;
               lost_nxt  = 1'b0;
            end
            default: state_nxt = state;
         endcase
      end else if (cnt == CNT_MAX) begin
         // Counter saturates; only a live state can time out
         if (state != LOST) begin
            state_nxt = LOST;
            lost_nxt  = 1'b1;
            valid_nxt = 1'b0;
         end
      end else begin
         cnt_nxt = cnt + CNT_ONE;
      end
   end

   // State, counter and output registers
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         cnt          <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         lost         <= 1'b0;
         tick_rise    <= 1'b0;
         tick_fall    <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         period       <= period_nxt;
         period_valid <= valid_nxt;
         lost         <= lost_nxt;
         tick_rise    <= tick_rise_nxt;
         tick_fall    <= tick_fall_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_clk_tick_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_tick_rx
// Brief    : Directed self-checking bench for clk_tick_rx (TIMEOUT=64, CNT_W=8).
//            Observes {tick_rise, tick_fall, period_valid, lost, period} once
//            per cycle on the falling edge of clk_in.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_tick_rx;

   localparam int CNT_W       = 8;
   localparam int TIMEOUT     = 64;
   localparam int SYNC_STAGES = 2;
`ifdef CLK_TICK_GLITCH_FILTER_EN
   localparam int LAT = 5;
`else
   localparam int LAT = 3;
`endif

   logic             clk_in   = 1'b0;
   logic             reset    = 1'b1;
   logic             slow_clk = 1'b0;
   logic             enable   = 1'b0;
   logic             tick_rise;
   logic             tick_fall;
   logic [CNT_W-1:0] period;
   logic             period_valid;
   logic             lost;

   int               checks = 0;
   int               errors = 0;
   int               tcyc   = 0;
   logic [11:0]      status;
   logic [11:0]      expv;

   assign status = {tick_rise, tick_fall, period_valid, lost, period};

   always #5 clk_in = ~clk_in;

   clk_tick_rx #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .clk_in       (clk_in),
      .reset        (reset),
      .slow_clk     (slow_clk),
      .enable       (enable),
      .tick_rise    (tick_rise),
      .tick_fall    (tick_fall),
      .period       (period),
      .period_valid (period_valid),
      .lost         (lost)
   );

   function automatic logic [11:0] pack(input logic tr, input logic tf,
                                        input logic v, input logic l,
                                        input logic [7:0] p);
      return {tr, tf, v, l, p};
   endfunction

   // Drive slow_clk for one clk_in cycle, then land on the next falling edge
   task automatic step(input logic v);
      slow_clk = v;
      @(negedge clk_in);
      tcyc++;
   endtask

   task automatic test_reset;
      int seen;
      seen = 0;
      #1 reset = 1'b0;
      enable = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step((k % 2) == 1);
         checks++;
         if (status !== 12'h000) begin
            errors++;
            $display("FAIL reset_hold k=%0d got=%h exp=000", k, status);
         end
      end
      enable = 1'b0;
      reset  = 1'b1;
      for (int k = 0; k < 30; k++) begin
         step((k % 6) < 3);
         if (tick_rise || tick_fall) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL reset_disabled_ticks got=%0d exp=0", seen);
      end
      for (int k = 0; k < 6; k++) step(1'b0);
      checks++;
      if (status !== 12'h000) begin
         errors++;
         $display("FAIL reset_disabled_outputs got=%h exp=000", status);
      end
   endtask

   task automatic test_lock;
      int t;
      enable = 1'b1;
      step(1'b0);
      step(1'b0);
      tcyc = 0;
      for (int k = 0; k < 60; k++) begin
         step((k % 20) < 10);
         t    = tcyc;
         expv = pack((t % 20) == LAT, (t % 20) == (LAT + 10), t >= 20 + LAT, 1'b0,
                     (t >= 20 + LAT) ? 8'd20 : 8'd0);
         checks++;
         if (status !== expv) begin
            errors++;
            $display("FAIL lock t=%0d got=%h exp=%h", t, status, expv);
         end
      end
   endtask

   task automatic test_timeout;
      int  t;
      logic l;
      for (int k = 60; k < 120; k++) begin
         step(1'b0);
         t    = tcyc;
         l    = (t >= 40 + LAT + TIMEOUT);
         expv = pack(1'b0, 1'b0, !l, l, 8'd20);
         checks++;
         if (status !== expv) begin
            errors++;
            $display("FAIL timeout t=%0d got=%h exp=%h", t, status, expv);
         end
      end
   endtask

   task automatic test_restart;
      int t;
      tcyc = 0;
      for (int k = 0; k < 60; k++) begin
         step((k % 20) < 10);
         t    = tcyc;
         expv = pack((t % 20) == LAT, (t % 20) == (LAT + 10), t >= 20 + LAT,
                     t < LAT, 8'd20);
         checks++;
         if (status !== expv) begin
            errors++;
            $display("FAIL restart t=%0d got=%h exp=%h", t, status, expv);
         end
      end
   endtask

   task automatic test_boundary;
      int t;
      tcyc = 0;
      for (int k = 0; k < 140; k++) begin
         step((k % 64) < 32);
         t    = tcyc;
         expv = pack((t % 64) == LAT, (t % 64) == (LAT + 32), 1'b1, 1'b0,
                     (t >= 64 + LAT) ? 8'd64 : 8'd20);
         checks++;
         if (status !== expv) begin
            errors++;
            $display("FAIL boundary t=%0d got=%h exp=%h", t, status, expv);
         end
      end
   endtask

   task automatic test_reenable;
      int t;
      enable = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step(1'b1);
         checks++;
         if (status !== 12'h000) begin
            errors++;
            $display("FAIL idle k=%0d got=%h exp=000", k, status);
         end
      end
      enable = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step(1'b1);
         checks++;
         if (status !== 12'h000) begin
            errors++;
            $display("FAIL reenable k=%0d got=%h exp=000", k, status);
         end
      end
      tcyc = 0;
      for (int k = 0; k < 30; k++) begin
         step(k >= 10);
         t    = tcyc;
         expv = pack(t == 10 + LAT, t == LAT, 1'b0, 1'b0, 8'd0);
         checks++;
         if (status !== expv) begin
            errors++;
            $display("FAIL reacquire t=%0d got=%h exp=%h", t, status, expv);
         end
      end
   endtask

   task automatic test_async_reset;
      int t;
      for (int k = 0; k < 60; k++) step((k % 20) >= 10);
      checks++;
      if (status !== pack(1'b0, 1'b0, 1'b1, 1'b0, 8'd20)) begin
         errors++;
         $display("FAIL pre_reset got=%h exp=%h", status,
                  pack(1'b0, 1'b0, 1'b1, 1'b0, 8'd20));
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (status !== 12'h000) begin
         errors++;
         $display("FAIL async_reset got=%h exp=000", status);
      end
      slow_clk = 1'b0;
      repeat (3) @(negedge clk_in);
      reset = 1'b1;
      tcyc  = 0;
      for (int k = 0; k < 30; k++) begin
         step((k % 20) < 10);
         t    = tcyc;
         expv = pack((t % 20) == LAT, (t % 20) == (LAT + 10), t >= 20 + LAT, 1'b0,
                     (t >= 20 + LAT) ? 8'd20 : 8'd0);
         checks++;
         if (status !== expv) begin
            errors++;
            $display("FAIL post_reset t=%0d got=%h exp=%h", t, status, expv);
         end
      end
   endtask

   task automatic test_pulse;
      int   t;
      logic [1:0] tk;
      logic [1:0] ek;
      for (int k = 0; k < 10; k++) step(1'b0);
`ifdef CLK_TICK_GLITCH_FILTER_EN
      for (int k = 0; k < 12; k++) begin
         step(k < 2);
         tk = {tick_rise, tick_fall};
         checks++;
         if (tk !== 2'b00) begin
            errors++;
            $display("FAIL glitch k=%0d got=%b exp=00", k, tk);
         end
      end
      tcyc = 0;
      for (int k = 0; k < 8; k++) begin
         step(1'b1);
         t  = tcyc;
         tk = {tick_rise, tick_fall};
         ek = {t == 5, 1'b0};
         checks++;
         if (tk !== ek) begin
            errors++;
            $display("FAIL filtered_rise t=%0d got=%b exp=%b", t, tk, ek);
         end
      end
`else
      tcyc = 0;
      for (int k = 0; k < 9; k++) begin
         step(k == 0);
         t  = tcyc;
         tk = {tick_rise, tick_fall};
         ek = {t == 3, t == 4};
         checks++;
         if (tk !== ek) begin
            errors++;
            $display("FAIL short_pulse t=%0d got=%b exp=%b", t, tk, ek);
         end
      end
`endif
   endtask

   initial begin
      test_reset();
      test_lock();
      test_timeout();
      test_restart();
      test_boundary();
      test_reenable();
      test_async_reset();
      test_pulse();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
